// File: rtl/bus_responder.sv
// bus_responder: target end of the control-strobe bus.
// Owns the ROM, the RAM, the switch buffer and the LED latch. It drives the
// shared data bus from the selected source. Write strobes are captured on one
// edge and committed on the next, and protocol faults are flagged as sticky bits.
module bus_responder #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          ADDR_W   = 4,
  parameter logic [DATA_W-1:0]    ROM_MULT = 8'h1D,
  parameter logic [DATA_W-1:0]    ROM_OFS  = 8'h5A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ROMO,
  input  logic              RAMO,
  input  logic              SWBEN,
  input  logic              RAMW,
  input  logic              LEDLTCH,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic [2:0]        err,
  output logic [15:0]       xfer_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } wr_state_t;

  wr_state_t         state;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] sw_meta;
  logic [DATA_W-1:0] sw_s;

  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_ram_we;
  logic              pend_led_we;

  logic [1:0]        drv_cnt;
  logic              drv_none;
  logic              drv_multi;
  logic              strobe;
  logic [DATA_W-1:0] rom_rd;
  logic [DATA_W-1:0] ram_rd;

  // ROM is a pure function of the address: a*ROM_MULT + ROM_OFS, wrapped to DATA_W
  always_comb begin
    rom_rd = DATA_W'(addr) * ROM_MULT + ROM_OFS;
  end

  // RAM read path: a pending write to the same word is forwarded ahead of the array
  always_comb begin
    if ((state == PEND) && pend_ram_we && (pend_addr == addr)) begin
      ram_rd = pend_data;
    end else begin
      ram_rd = ram[addr];
    end
  end

  // Bus mux: only a single active driver puts data on the bus, otherwise it reads zero
  always_comb begin
    drv_cnt   = {1'b0, ROMO} + {1'b0, RAMO} + {1'b0, SWBEN};
    drv_none  = (drv_cnt == 2'd0);
    drv_multi = (drv_cnt >= 2'd2);
    strobe    = RAMW | LEDLTCH;
    bus       = '0;
    if (drv_cnt == 2'd1) begin
      if (ROMO) begin
        bus = rom_rd;
      end else if (RAMO) begin
        bus = ram_rd;
      end else begin
        bus = sw_s;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  // RAM array: cleared on reset, written only by a committed transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if ((state == PEND) && pend_ram_we) begin
      ram[pend_addr] <= pend_data;
    end
  end

  // Write FSM: capture in IDLE, commit in PEND, plus the sticky fault flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      leds        <= '0;
      err         <= '0;
      xfer_count  <= '0;
      pend_data   <= '0;
      pend_addr   <= '0;
      pend_ram_we <= 1'b0;
      pend_led_we <= 1'b0;
    end else begin
      if (drv_multi) begin
        err[0] <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (strobe) begin
            // bus already reads zero for the no-driver and multi-driver cases
            pend_data   <= bus;
            pend_addr   <= addr;
            pend_ram_we <= RAMW;
            pend_led_we <= LEDLTCH;
            state       <= PEND;
            busy        <= 1'b1;
            if (drv_none) begin
              err[1] <= 1'b1;
            end
          end
        end
        PEND: begin
          if (pend_led_we) begin
            leds <= pend_data;
          end
          if (xfer_count != 16'hFFFF) begin
            xfer_count <= xfer_count + 16'd1;
          end
          state <= IDLE;
          busy  <= 1'b0;
          if (strobe) begin
            err[2] <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed and random stimulus for bus_responder, checked
// against a transaction-level reference model (memory array, queue of pending transfers).
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       ROMO, RAMO, SWBEN, RAMW, LEDLTCH;
  logic [3:0] addr;
  logic [7:0] sw;
  logic [7:0] bus;
  logic [7:0] leds;
  logic       busy;
  logic [2:0] err;
  logic [15:0] xfer_count;

  always #5 clk = ~clk;

  bus_responder #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .ROM_MULT(8'h1D),
    .ROM_OFS (8'h5A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ROMO      (ROMO),
    .RAMO      (RAMO),
    .SWBEN     (SWBEN),
    .RAMW      (RAMW),
    .LEDLTCH   (LEDLTCH),
    .addr      (addr),
    .sw        (sw),
    .bus       (bus),
    .leds      (leds),
    .busy      (busy),
    .err       (err),
    .xfer_count(xfer_count)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] a;
    bit         to_ram;
    bit         to_led;
  } xfer_t;

  xfer_t       pq[$];
  logic [7:0]  mram [16];
  logic [7:0]  mleds;
  logic [2:0]  merr;
  int unsigned mcount;
  logic [7:0]  swq[$];

  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] rom_m(int a);
    return 8'((a * 'h1D + 'h5A) % 256);
  endfunction

  function automatic int drivers();
    return int'(ROMO) + int'(RAMO) + int'(SWBEN);
  endfunction

  function automatic logic [7:0] model_bus();
    if (drivers() != 1) return 8'h00;
    if (ROMO) return rom_m(int'(addr));
    if (RAMO) begin
      if (pq.size() > 0 && pq[0].to_ram && pq[0].a == addr) return pq[0].data;
      return mram[addr];
    end
    return swq[0];
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Apply one clock edge to the reference model using the inputs currently driven.
  task automatic model_edge();
    xfer_t t;
    if (reset) begin
      pq.delete();
      for (int i = 0; i < 16; i++) mram[i] = 8'h00;
      mleds  = 8'h00;
      merr   = 3'b000;
      mcount = 0;
      swq    = '{8'h00, 8'h00};
    end else begin
      if (drivers() >= 2) merr[0] = 1'b1;
      if (pq.size() > 0) begin
        t = pq.pop_front();
        if (t.to_ram) mram[t.a] = t.data;
        if (t.to_led) mleds = t.data;
        if (mcount < 65535) mcount++;
        if (RAMW || LEDLTCH) merr[2] = 1'b1;
      end else if (RAMW || LEDLTCH) begin
        t.data   = model_bus();
        t.a      = addr;
        t.to_ram = RAMW;
        t.to_led = LEDLTCH;
        if (drivers() == 0) merr[1] = 1'b1;
        pq.push_back(t);
      end
      swq.push_back(sw);
      void'(swq.pop_front());
    end
  endtask

  task automatic set_in(input logic rst, input logic romo, input logic ramo, input logic swb,
                        input logic rw, input logic lt, input logic [3:0] a, input logic [7:0] s);
    reset = rst; ROMO = romo; RAMO = ramo; SWBEN = swb;
    RAMW = rw; LEDLTCH = lt; addr = a; sw = s;
  endtask

  // One cycle: compare outputs with the model mid-cycle, then advance DUT and model together.
  task automatic cycle(input bit chk);
    #1;
    if (chk) begin
      check("bus",   {8'h00, bus},  {8'h00, model_bus()});
      check("leds",  {8'h00, leds}, {8'h00, mleds});
      check("busy",  {15'h0, busy}, {15'h0, pq.size() > 0});
      check("err",   {13'h0, err},  {13'h0, merr});
      check("xfer",  xfer_count,    16'(mcount));
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic rst, input logic romo, input logic ramo, input logic swb,
                      input logic rw, input logic lt, input logic [3:0] a, input logic [7:0] s);
    set_in(rst, romo, ramo, swb, rw, lt, a, s);
    cycle(1'b1);
  endtask

  initial begin
    // reset
    set_in(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    cycle(1'b0);
    step(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    check("rst_leds", {8'h00, leds}, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_err",  {13'h0, err},  16'h0000);
    check("rst_xfer", xfer_count,    16'h0000);

    // ROM read is combinational
    set_in(0, 1, 0, 0, 0, 0, 4'd3, 8'h00);
    #1;
    check("rom3", {8'h00, bus}, 16'h00B1);
    cycle(1'b1);
    check("rom_err", {13'h0, err}, 16'h0000);

    // switch -> RAM[5] -> LEDs
    step(0, 0, 0, 0, 0, 0, 4'd0, 8'hC3);
    step(0, 0, 0, 0, 0, 0, 4'd0, 8'hC3);
    step(0, 0, 0, 1, 1, 0, 4'd5, 8'hC3);
    check("sw_busy", {15'h0, busy}, 16'h0001);
    step(0, 0, 0, 0, 0, 0, 4'd5, 8'hC3);
    set_in(0, 0, 1, 0, 0, 0, 4'd5, 8'hC3);
    #1;
    check("ram5", {8'h00, bus}, 16'h00C3);
    check("xfer1", xfer_count, 16'd1);
    cycle(1'b1);
    step(0, 0, 1, 0, 0, 1, 4'd5, 8'hC3);
    step(0, 0, 0, 0, 0, 0, 4'd0, 8'hC3);
    check("leds_c3", {8'h00, leds}, 16'h00C3);
    check("xfer2", xfer_count, 16'd2);

    // forwarding of pending data in the busy cycle
    step(0, 1, 0, 0, 1, 0, 4'd1, 8'hC3);
    set_in(0, 0, 1, 0, 0, 0, 4'd1, 8'hC3);
    #1;
    check("fwd", {8'h00, bus}, 16'h0077);
    cycle(1'b1);

    // overrun: second strobe while busy is dropped
    step(1, 0, 0, 0, 0, 0, 4'd0, 8'hC3);
    step(0, 1, 0, 0, 1, 0, 4'd0, 8'hC3);
    step(0, 0, 0, 1, 1, 0, 4'd2, 8'hC3);
    step(0, 0, 1, 0, 0, 0, 4'd0, 8'hC3);
    check("ovr_ram0", {8'h00, bus}, 16'h005A);
    check("ovr_err", {13'h0, err}, 16'h0004);
    check("ovr_xfer", xfer_count, 16'd1);
    set_in(0, 0, 1, 0, 0, 0, 4'd2, 8'hC3);
    #1;
    check("ovr_ram2", {8'h00, bus}, 16'h0000);
    cycle(1'b1);

    // faults: multi-driver and strobe with no driver, both sticky
    step(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    set_in(0, 1, 1, 0, 0, 0, 4'd4, 8'h00);
    #1;
    check("multi_bus", {8'h00, bus}, 16'h0000);
    cycle(1'b1);
    check("multi_err", {13'h0, err}, 16'h0001);
    step(0, 0, 0, 0, 0, 1, 4'd0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    check("nodrv_leds", {8'h00, leds}, 16'h0000);
    check("sticky_err", {13'h0, err}, 16'h0003);
    step(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    check("err_clr", {13'h0, err}, 16'h0000);

    // reset in the busy cycle discards the pending write
    step(0, 1, 0, 0, 0, 1, 4'd1, 8'h00);
    step(1, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 4'd0, 8'h00);
    check("rmw_leds", {8'h00, leds}, 16'h0000);
    check("rmw_busy", {15'h0, busy}, 16'h0000);
    check("rmw_xfer", xfer_count, 16'h0000);

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : sw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
